// File: rtl/prog_loader_if.sv
// Host-side word stream into the program loader: valid/ready handshake with a last-word marker.
interface prog_loader_if #(
  parameter int BIT_DATA = 16
);
  logic                s_valid;
  logic                s_ready;
  logic [BIT_DATA-1:0] s_data;
  logic                s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/prog_loader.sv
// Replays a host word stream into the cpu instruction-load port as
// interrupt / {LD_OP, addr} / word / exit-marker sequences.
module prog_loader #(
  parameter int              BIT_INST = 16,
  parameter int              BIT_DATA = 16,
  parameter int              OP_W     = 4,
  parameter logic [OP_W-1:0] LD_OP    = 4'hE,
  parameter int              ADDR_W   = 4,
  parameter int              SZA_INS  = 16,
  parameter int              HOLD     = 4
) (
  input  logic                clock,
  input  logic                reset,
  prog_loader_if.slave        host,
  input  logic                abort,
  output logic                interrupt,
  output logic [BIT_INST-1:0] io_inst,
  output logic [BIT_DATA-1:0] io_din,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     count,
  output logic                err
);

  localparam int                PH_W      = $clog2(HOLD) + 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(HOLD - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SZA_INS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, EXIT} state_t;

  state_t              state, state_n;
  logic [PH_W-1:0]     ph, ph_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [BIT_DATA-1:0] word, word_n;
  logic                last, last_n;
  logic                interrupt_n;
  logic [BIT_INST-1:0] io_inst_n;
  logic [BIT_DATA-1:0] io_din_n;
  logic                done_n;
  logic [ADDR_W:0]     count_n;
  logic                err_n;
  logic                xfer;
  logic                phase_end;

  function automatic logic [BIT_INST-1:0] ld_inst(input logic [ADDR_W-1:0] a);
    logic [BIT_INST-1:0] w;
    w = '0;
    w[BIT_INST-1 -: OP_W] = LD_OP;
    w[BIT_INST-OP_W-1 -: ADDR_W] = a;
    return w;
  endfunction

  // abort in WAIT blocks the handshake so a simultaneous word is left with the host
  assign host.s_ready = (state == IDLE) || ((state == WAIT) && !abort);
  assign xfer         = host.s_valid && host.s_ready;
  assign phase_end    = (ph == PH_LAST);
  assign busy         = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ph        <= '0;
      addr      <= '0;
      word      <= '0;
      last      <= 1'b0;
      interrupt <= 1'b0;
      io_inst   <= '0;
      io_din    <= '0;
      done      <= 1'b0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      addr      <= addr_n;
      word      <= word_n;
      last      <= last_n;
      interrupt <= interrupt_n;
      io_inst   <= io_inst_n;
      io_din    <= io_din_n;
      done      <= done_n;
      count     <= count_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    ph_n        = ph;
    addr_n      = addr;
    word_n      = word;
    last_n      = last;
    interrupt_n = interrupt;
    io_inst_n   = io_inst;
    io_din_n    = io_din;
    done_n      = 1'b0;
    count_n     = count;
    err_n       = err;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_n     = ADDR;
          ph_n        = '0;
          addr_n      = '0;
          word_n      = host.s_data;
          last_n      = host.s_last;
          interrupt_n = 1'b1;
          io_inst_n   = ld_inst('0);
          count_n     = {{ADDR_W{1'b0}}, 1'b1};
          err_n       = 1'b0;
        end
      end
      ADDR: begin
        if (phase_end) begin
          state_n  = DATA;
          ph_n     = '0;
          io_din_n = word;
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      DATA: begin
        if (phase_end) begin
          ph_n = '0;
          // the last slot without an s_last marker ends the session as an overflow
          if (last || (addr == ADDR_LAST)) begin
            state_n   = EXIT;
            io_inst_n = '1;
            if (!last) err_n = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      WAIT: begin
        if (abort) begin
          state_n   = EXIT;
          ph_n      = '0;
          io_inst_n = '1;
        end else if (xfer) begin
          state_n   = ADDR;
          ph_n      = '0;
          addr_n    = addr + 1'b1;
          word_n    = host.s_data;
          last_n    = host.s_last;
          io_inst_n = ld_inst(addr + 1'b1);
          count_n   = count + 1'b1;
        end
      end
      EXIT: begin
        if (phase_end) begin
          state_n     = IDLE;
          ph_n        = '0;
          interrupt_n = 1'b0;
          io_inst_n   = '0;
          io_din_n    = '0;
          done_n      = 1'b1;
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
